// File: rtl/gf180mcu_skid_pkg.sv
// ============================================================================
// Module   : gf180mcu_skid_pkg
// Brief    : Shared state encoding and default sizes for the skid stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gf180mcu_skid_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_STALL_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/gf180mcu_mcu9t5v0_skid_stage_func.sv
// ============================================================================
// Module   : gf180mcu_mcu9t5v0_skid_stage_func
// Brief    : Two-entry skid buffer state machine and datapath.
//            Optional stall counter under SKID_STAGE_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gf180mcu_mcu9t5v0_skid_stage_func
    import gf180mcu_skid_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef SKID_STAGE_STALL_CNT_EN
    ,
    parameter int STALL_W = DEFAULT_STALL_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
`ifdef SKID_STAGE_STALL_CNT_EN
    output logic [STALL_W-1:0] stall_cnt,
`endif
    input  logic             out_ready
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_skid;
    logic             r_valid;
    logic             r_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // Reset gates acceptance combinationally so nothing slips in while RST=1.
    assign in_ready   = r_ready & ~rst;
    assign w_in_fire  = in_valid & r_ready;
    assign w_out_fire = r_valid & out_ready;

    assign out_data   = r_data;
    assign out_valid  = r_valid;

    // r_valid and r_ready track "state != EMPTY" and "state != FULL" as flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_data  <= in_data;
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_data <= in_data;
                    end else if (w_in_fire) begin
                        r_skid  <= in_data;
                        r_state <= FULL;
                        r_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        r_data  <= r_skid;
                        r_state <= ONE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SKID_STAGE_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/gf180mcu_mcu9t5v0_skid_stage.sv
// ============================================================================
// Module   : gf180mcu_mcu9t5v0_skid_stage
// Brief    : Registered valid/ready skid stage feeding a 9-track buffer column.
//            Macros: SKID_STAGE_STALL_CNT_EN (stall counter), FUNCTIONAL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gf180mcu_mcu9t5v0_skid_stage
    import gf180mcu_skid_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int STALL_W = DEFAULT_STALL_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   I,
    input  logic               I_VALID,
    output logic               I_READY,
    output logic [WIDTH-1:0]   Z,
    output logic               Z_VALID,
    input  logic               Z_READY,
`ifdef SKID_STAGE_STALL_CNT_EN
    output logic [STALL_W-1:0] STALL_CNT,
`endif
    inout  wire                VDD,
    inout  wire                VSS
);

    logic [WIDTH-1:0] w_z;
    logic             w_z_valid;

    // Illegal sizes leave this marker block elaborated for easy spotting.
    if (WIDTH < 1 || WIDTH > 64 || STALL_W < 1) begin : g_bad_param
    end

    gf180mcu_mcu9t5v0_skid_stage_func #(
        .WIDTH     (WIDTH)
`ifdef SKID_STAGE_STALL_CNT_EN
        ,
        .STALL_W   (STALL_W)
`endif
    ) u_func (
        .clk       (CLK),
        .rst       (RST),
        .in_data   (I),
        .in_valid  (I_VALID),
        .in_ready  (I_READY),
        .out_data  (w_z),
        .out_valid (w_z_valid),
`ifdef SKID_STAGE_STALL_CNT_EN
        .stall_cnt (STALL_CNT),
`endif
        .out_ready (Z_READY)
    );

`ifndef FUNCTIONAL
    logic w_supply_ok;

    assign w_supply_ok = (VDD === 1'b1) && (VSS === 1'b0);
    assign Z           = w_supply_ok ? w_z : {WIDTH{1'bx}};
    assign Z_VALID     = w_supply_ok ? w_z_valid : 1'bx;

    specify
        (CLK *> Z)       = 1.0;
        (CLK => Z_VALID) = 1.0;
        (CLK => I_READY) = 1.0;
    endspecify
`else
    assign Z       = w_z;
    assign Z_VALID = w_z_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_mcu9t5v0_skid_stage.sv
// Randomized scoreboard bench for the skid stage: a capacity-2 FIFO model
// predicts Z, Z_VALID, I_READY (and STALL_CNT when enabled).
`default_nettype none

module tb_gf180mcu_mcu9t5v0_skid_stage;

    localparam int WIDTH = 8;
`ifdef SKID_STAGE_STALL_CNT_EN
    localparam int STALL_W = 4;
`else
    localparam int STALL_W = 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             z_ready;
    wire              vdd;
    wire              vss;
`ifdef SKID_STAGE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt;
    int                 stall_model = 0;
`endif

    assign vdd = 1'b1;
    assign vss = 1'b0;

    always #5 clk = ~clk;

    gf180mcu_mcu9t5v0_skid_stage #(
        .WIDTH     (WIDTH),
        .STALL_W   (STALL_W)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .I         (din),
        .I_VALID   (din_valid),
        .I_READY   (din_ready),
        .Z         (z),
        .Z_VALID   (z_valid),
        .Z_READY   (z_ready),
`ifdef SKID_STAGE_STALL_CNT_EN
        .STALL_CNT (stall_cnt),
`endif
        .VDD       (vdd),
        .VSS       (vss)
    );

    logic [WIDTH-1:0] sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  just_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: sees the DUT state settled between edges.
    always @(negedge clk) begin
        if (just_reset) begin
            sb.delete();
            check("reset_z", 64'(z), 64'd0);
        end
        check("z_valid", 64'(z_valid), 64'(sb.size() != 0));
        check("i_ready", 64'(din_ready), 64'((sb.size() < 2) && !rst));
        if (z_valid && sb.size() != 0)
            check("z_data", 64'(z), 64'(sb[0]));
`ifdef SKID_STAGE_STALL_CNT_EN
        if (just_reset) stall_model = 0;
        check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
        if (rst)
            stall_model = 0;
        else if (sb.size() != 0 && !z_ready && stall_model < (1 << STALL_W) - 1)
            stall_model++;
`endif
        if (z_valid && z_ready && !rst && sb.size() != 0)
            void'(sb.pop_front());
        just_reset = rst;
    end

    // One cycle of stimulus; records the accepted beat after the monitor ran.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic zr);
        @(posedge clk);
        #1;
        rst       = r;
        din_valid = v;
        din       = d;
        z_ready   = zr;
        @(negedge clk);
        #1;
        if (din_valid && din_ready)
            sb.push_back(din);
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'hA5;
        z_ready   = 1'b1;
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        // Release: first cycle shows I_READY=1 with nothing emitted.
        step(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 1; i <= 16; i++)
            step(1'b0, 1'b1, 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, (sb.size() < 3) && (i < 2), 8'h33, 1'b1);

        // Fill, then a single-cycle drain pulse.
        step(1'b0, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 8'h66, 1'b1);
        step(1'b0, 1'b1, 8'h66, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset while FULL drops both beats.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Long stall exercises counter saturation when present.
        step(1'b0, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 10000; i++)
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1);

        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
